muldiv_sequencer: RTL

//  Iterative multiply/divide sequencer for the mult/multu/div/divu datapath; owns the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and counter sizing shared by the multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add for multiply or restoring trial-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0] sum, sh, diff;

   always_comb begin
      sum  = {1'b0, hi_i} + {1'b0, {WIDTH{lo_i[0]}} & opd_i};
      // the extra remainder bit lets diff[WIDTH] act as the trial-subtract borrow
      sh   = {hi_i, lo_i[WIDTH-1]};
      diff = sh - {1'b0, opd_i};
      hi_o = is_div_i ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo_o = is_div_i ? {lo_i[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_i[WIDTH-1:1]};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// Signed mult/div with sign fixup is built only when MULDIV_SIGNED_EN is defined.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opd_q, opd_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             is_div_q, is_div_d, dz_q, dz_d;
   logic [WIDTH-1:0] step_hi, step_lo, a_abs, b_abs, hi_res, lo_res;
   logic             accept, zero;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .hi_i     (acc_hi_q),
      .lo_i     (acc_lo_q),
      .opd_i    (opd_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

`ifdef MULDIV_SIGNED_EN
   logic sgn, neg_q, neg_d, rneg_q, rneg_d;

   always_comb begin
      sgn    = ~op[0];
      a_abs  = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
      b_abs  = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
      neg_d  = accept ? sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]) & ~zero : neg_q;
      rneg_d = accept ? sgn & op[1] & rs_val[WIDTH-1] & ~zero : rneg_q;
      // negating the full product carries into HI only when LO is zero
      hi_res = is_div_q ? (rneg_q ? -acc_hi_q : acc_hi_q)
                        : (neg_q ? ~acc_hi_q + WIDTH'(acc_lo_q == '0) : acc_hi_q);
      lo_res = neg_q ? -acc_lo_q : acc_lo_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
      end
   end
`else
   logic unused_op0;
   assign unused_op0 = op[0];
   assign a_abs      = rs_val;
   assign b_abs      = rt_val;
   assign hi_res     = acc_hi_q;
   assign lo_res     = acc_lo_q;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opd_d    = opd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      busy     = state_q == RUN || state_q == FIX;
      done     = state_q == DONE;
      accept   = start && (state_q == IDLE || state_q == DONE);
      zero     = op[1] && rt_val == '0;
      if (accept) begin
         state_d  = zero ? FIX : RUN;
         cnt_d    = '0;
         is_div_d = op[1];
         dz_d     = zero;
         // divide-by-zero preloads the architected result so FIX just commits it
         acc_hi_d = zero ? rs_val : '0;
         acc_lo_d = zero ? '1 : (op[1] ? a_abs : b_abs);
         opd_d    = op[1] ? b_abs : a_abs;
      end else if (state_q == RUN) begin
         state_d  = cnt_q == CW'(WIDTH-1) ? FIX : RUN;
         cnt_d    = cnt_q + CW'(1);
         acc_hi_d = step_hi;
         acc_lo_d = step_lo;
      end else if (state_q == FIX) begin
         state_d = DONE;
         hi_d    = hi_res;
         lo_d    = lo_res;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opd_q    <= opd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
      end
   end

   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
